// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate-format enum,
// decode FSM state enum and a helper classifying opcodes that write rd.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_READ,
        ST_CAPT,
        ST_HOLD
    } dec_state_e;

    // Opcodes whose result lands in rd; anything else (incl. illegal) never writes.
    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
            default:                      writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: classifies the instruction format from
// the opcode and builds the sign-extended 32-bit immediate (0 for R-type and
// unknown opcodes).
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output imm_fmt_e    fmt,
    output logic [31:0] imm
);

    logic signed [31:0] imm_s;

    // Map opcode to immediate format.
    always_comb begin
        fmt = FMT_NONE;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_FENCE, OPC_SYSTEM:       fmt = FMT_I;
            OPC_STORE:                   fmt = FMT_S;
            OPC_BRANCH:                  fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:          fmt = FMT_U;
            OPC_JAL:                     fmt = FMT_J;
            default:                     fmt = FMT_NONE;
        endcase
    end

    // Assemble the immediate bits for the selected format; instr[31] is the sign.
    always_comb begin
        imm_s = '0;
        case (fmt)
            FMT_I: imm_s = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm_s = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm_s = {instr[31:12], 12'b0};
            FMT_J: imm_s = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm_s = '0;
        endcase
    end

    assign imm = imm_s;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage. Accepts one instruction from fetch,
// drives rs1/rs2 to the two-phase register file, waits for its read slot
// (capture at a phase==0 edge, data valid one edge later), then presents the
// decoded bundle to execute until it is accepted.
// Optional feature: define DECODE_BYPASS_EN to add the wb_* writeback bypass
// ports; without it operands come only from the register file and the issue
// controller must stall read-after-write hazards.
module decode_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic [31:0] rf_rs1_v,
    input  logic [31:0] rf_rs2_v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_illegal
`ifdef DECODE_BYPASS_EN
    ,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_v
`endif
);

    dec_state_e  state, state_nx;
    logic        phase;
    logic        accept;
    logic        capt;
    logic [31:0] instr_p0;
    logic [31:0] pc_p0;
    logic [4:0]  rs1_p0;
    logic [4:0]  rs2_p0;
    logic [31:0] op1_nx;
    logic [31:0] op2_nx;
    imm_fmt_e    fmt_p0;
    logic [31:0] imm_p0;

    assign rs1_p0 = instr_p0[19:15];
    assign rs2_p0 = instr_p0[24:20];

    imm_gen u_imm_gen (
        .instr (instr_p0),
        .fmt   (fmt_p0),
        .imm   (imm_p0)
    );

    // Local copy of the register file's read/write phase; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= 1'b1;
        else        phase <= ~phase;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capt     = 1'b0;
        if (flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        accept   = 1'b1;
                        state_nx = ST_ALIGN;
                    end
                end
                ST_ALIGN: if (!phase) state_nx = ST_READ;
                ST_READ:  state_nx = ST_CAPT;
                ST_CAPT: begin
                    capt     = 1'b1;
                    state_nx = ST_HOLD;
                end
                ST_HOLD:  if (out_ready) state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);

    // Operand select: rf data, optional writeback override, x0 forced to zero.
    always_comb begin
        op1_nx = rf_rs1_v;
        op2_nx = rf_rs2_v;
`ifdef DECODE_BYPASS_EN
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_p0)) op1_nx = wb_v;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_p0)) op2_nx = wb_v;
`endif
        if (rs1_p0 == 5'd0) op1_nx = '0;
        if (rs2_p0 == 5'd0) op2_nx = '0;
    end

    // ---- stage p0: latch the accepted instruction and drive rf addresses ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p0 <= '0;
            pc_p0    <= '0;
            rf_rs1   <= '0;
            rf_rs2   <= '0;
        end else if (accept) begin
            instr_p0 <= in_instr;
            pc_p0    <= in_pc;
            rf_rs1   <= in_instr[19:15];
            rf_rs2   <= in_instr[24:20];
        end
    end

    // ---- stage p1: capture operands and decoded fields into the bundle ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc       <= '0;
            out_op1      <= '0;
            out_op2      <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (capt) begin
            out_pc       <= pc_p0;
            out_op1      <= op1_nx;
            out_op2      <= op2_nx;
            out_imm      <= imm_p0;
            out_rd       <= instr_p0[11:7];
            out_rd_we    <= writes_rd(instr_p0[6:0]) && (instr_p0[11:7] != 5'd0);
            out_opcode   <= instr_p0[6:0];
            out_funct3   <= instr_p0[14:12];
            out_funct7b5 <= instr_p0[30];
            out_illegal  <= (fmt_p0 == FMT_NONE) && (instr_p0[6:0] != OPC_OP);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: table of directed instructions with
// hand-computed bundles, plus sequences for back-pressure, flush, reset and
// (when DECODE_BYPASS_EN is defined) writeback bypass. Includes a model of
// the two-phase register file's read timing.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_v, rf_rs2_v;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_op1, out_op2, out_imm;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_illegal;
`ifdef DECODE_BYPASS_EN
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_v;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_rs1_v     (rf_rs1_v),
        .rf_rs2_v     (rf_rs2_v),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_op1      (out_op1),
        .out_op2      (out_op2),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_illegal  (out_illegal)
`ifdef DECODE_BYPASS_EN
        ,
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_v         (wb_v)
`endif
    );

    // Register file model: address captured on a phase==0 edge, data driven
    // on the following edge and held for two cycles; garbage before that.
    logic        ph;
    logic [31:0] regs [32];
    logic [4:0]  cap1, cap2;
    logic [31:0] rd1 = 32'hBAD0BAD0;
    logic [31:0] rd2 = 32'hBAD0BAD0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= 1'b1;
        else        ph <= ~ph;
    end

    always @(posedge clk) begin
        if (!ph) begin
            cap1 <= rf_rs1;
            cap2 <= rf_rs2;
        end else begin
            rd1 <= regs[cap1];
            rd2 <= regs[cap2];
        end
    end

    assign rf_rs1_v = rd1;
    assign rf_rs2_v = rd2;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
        logic        ill;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Send one instruction and check latency, rf addresses and the bundle.
    // With hold=1, out_ready is kept low for 5 cycles after out_valid.
    task automatic run_vec(input vec_t v, input int tag, input bit hold);
        int k;
        int n;
        int exp_lat;
        logic [31:0] imm_s, op1_s;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d_in_ready_wait", tag), 32'(in_ready), 32'd1);
        out_ready = hold ? 1'b0 : 1'b1;
        in_valid  = 1'b1;
        in_instr  = v.instr;
        in_pc     = v.pc;
        exp_lat   = (ph == 1'b1) ? 3 : 4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk($sformatf("v%0d_in_ready_busy", tag), 32'(in_ready), 32'd0);
        chk($sformatf("v%0d_rf_rs1", tag), 32'(rf_rs1), 32'(v.rs1));
        chk($sformatf("v%0d_rf_rs2", tag), 32'(rf_rs2), 32'(v.rs2));
        n = 0;
        while (!out_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("v%0d_latency", tag), 32'(n), 32'(exp_lat));
        chk($sformatf("v%0d_pc", tag), out_pc, v.pc);
        chk($sformatf("v%0d_op1", tag), out_op1, v.op1);
        chk($sformatf("v%0d_op2", tag), out_op2, v.op2);
        chk($sformatf("v%0d_imm", tag), out_imm, v.imm);
        chk($sformatf("v%0d_rd", tag), 32'(out_rd), 32'(v.rd));
        chk($sformatf("v%0d_rd_we", tag), 32'(out_rd_we), 32'(v.we));
        chk($sformatf("v%0d_opcode", tag), 32'(out_opcode), 32'(v.opc));
        chk($sformatf("v%0d_funct3", tag), 32'(out_funct3), 32'(v.f3));
        chk($sformatf("v%0d_f7b5", tag), 32'(out_funct7b5), 32'(v.f7b5));
        chk($sformatf("v%0d_illegal", tag), 32'(out_illegal), 32'(v.ill));
        if (hold) begin
            imm_s = out_imm;
            op1_s = out_op1;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_hold_valid%0d", tag, c), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d_hold_ready%0d", tag, c), 32'(in_ready), 32'd0);
                chk($sformatf("v%0d_hold_imm%0d", tag, c), out_imm, imm_s);
                chk($sformatf("v%0d_hold_op1%0d", tag, c), out_op1, op1_s);
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_valid", tag), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d_done_ready", tag), 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int seen;
        vec_t v;

        for (int i = 0; i < 32; i++) regs[i] = 32'h0A000000 | 32'(i);
        regs[0] = 32'hDEADBEEF;
        regs[1] = 32'h11111111;
        regs[2] = 32'h00000007;
        regs[3] = 32'h33333333;

        //          instr         pc            rs1    rs2    op1           op2           imm           rd      we    opc       f3    f7b5  ill
        vecs[0] = '{32'h00510093, 32'h00001000, 5'd2,  5'd5,  32'h00000007, 32'h0A000005, 32'h00000005, 5'd1,  1'b1, 7'h13, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{32'h00208033, 32'h00001004, 5'd1,  5'd2,  32'h11111111, 32'h00000007, 32'h00000000, 5'd0,  1'b0, 7'h33, 3'd0, 1'b0, 1'b0};
        vecs[2] = '{32'h123452B7, 32'h00001008, 5'd8,  5'd3,  32'h0A000008, 32'h33333333, 32'h12345000, 5'd5,  1'b1, 7'h37, 3'd5, 1'b0, 1'b0};
        vecs[3] = '{32'h00312423, 32'h0000100C, 5'd2,  5'd3,  32'h00000007, 32'h33333333, 32'h00000008, 5'd8,  1'b0, 7'h23, 3'd2, 1'b0, 1'b0};
        vecs[4] = '{32'hFE000EE3, 32'h00001010, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFC, 5'd29, 1'b0, 7'h63, 3'd0, 1'b1, 1'b0};
        vecs[5] = '{32'h001100FF, 32'h00001014, 5'd2,  5'd1,  32'h00000007, 32'h11111111, 32'h00000000, 5'd1,  1'b0, 7'h7F, 3'd0, 1'b0, 1'b1};
        vecs[6] = '{32'h008000EF, 32'h00001018, 5'd0,  5'd8,  32'h00000000, 32'h0A000008, 32'h00000008, 5'd1,  1'b1, 7'h6F, 3'd0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFF1A383, 32'h0000101C, 5'd3,  5'd31, 32'h33333333, 32'h0A00001F, 32'hFFFFFFFF, 5'd7,  1'b1, 7'h03, 3'd2, 1'b1, 1'b0};
        vecs[8] = '{32'h402081B3, 32'h00001020, 5'd1,  5'd2,  32'h11111111, 32'h00000007, 32'h00000000, 5'd3,  1'b1, 7'h33, 3'd0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
`ifdef DECODE_BYPASS_EN
        wb_we = 1'b0;
        wb_rd = '0;
        wb_v  = '0;
`endif
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rf_rs1", 32'(rf_rs1), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i, 1'b0);

        // Back-pressure with acceptance on each phase value.
        for (int p = 0; p < 2; p++) begin
            if (ph != p[0]) @(negedge clk);
            run_vec(vecs[0], 10 + p, 1'b1);
        end

        // Flush while the stage waits on the register-file read.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = vecs[2].instr;
        in_pc     = vecs[2].pc;
        lat       = (ph == 1'b1) ? 3 : 4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (lat - 2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_read_valid", 32'(out_valid), 32'd0);
        chk("flush_read_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("flush_read_no_bundle", 32'(seen), 32'd0);
        @(negedge clk);

        // Flush coincident with an offer in IDLE drops it.
        in_valid = 1'b1;
        flush    = 1'b1;
        in_instr = vecs[1].instr;
        in_pc    = 32'h0000BEEF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_idle_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("flush_idle_no_bundle", 32'(seen), 32'd0);
        @(negedge clk);
        run_vec(vecs[3], 20, 1'b0);

        // Reset pulse while the bundle is held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = vecs[7].instr;
        in_pc     = vecs[7].pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 8) begin
            @(posedge clk);
            #1;
            seen++;
        end
        chk("rsthold_reached", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rsthold_out_valid", 32'(out_valid), 32'd0);
        chk("rsthold_in_ready", 32'(in_ready), 32'd1);
        chk("rsthold_pc", out_pc, 32'd0);
        chk("rsthold_op1", out_op1, 32'd0);
        chk("rsthold_op2", out_op2, 32'd0);
        chk("rsthold_imm", out_imm, 32'd0);
        chk("rsthold_rd", 32'(out_rd), 32'd0);
        chk("rsthold_rd_we", 32'(out_rd_we), 32'd0);
        chk("rsthold_opcode", 32'(out_opcode), 32'd0);
        chk("rsthold_funct3", 32'(out_funct3), 32'd0);
        chk("rsthold_f7b5", 32'(out_funct7b5), 32'd0);
        chk("rsthold_rf_rs1", 32'(rf_rs1), 32'd0);
        chk("rsthold_rf_rs2", 32'(rf_rs2), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        run_vec(vecs[4], 21, 1'b0);

`ifdef DECODE_BYPASS_EN
        // Writeback to x2 overrides rs1 of addi; rs2 (x5) still from rf.
        wb_we = 1'b1;
        wb_rd = 5'd2;
        wb_v  = 32'h00000055;
        v     = vecs[0];
        v.op1 = 32'h00000055;
        run_vec(v, 30, 1'b0);
        wb_we = 1'b0;
`else
        v = vecs[0];
        run_vec(v, 31, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
